// File: rtl/slant_tx_framer.sv
// Buffers SlantMem transmit lanes in a word FIFO and emits framed bytes.
// Define SLANT_TX_CHKSUM_EN to append an XOR checksum byte to each packet.
module slant_tx_framer #(
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_WORDS  = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         TransValid,
    input  logic [7:0]                   Trans0Data,
    input  logic [7:0]                   Trans1Data,
    input  logic [7:0]                   Trans2Data,
    input  logic [7:0]                   Trans3Data,
    output logic [7:0]                   TxData,
    output logic                         TxValid,
    input  logic                         TxReady,
    output logic                         TxSof,
    output logic                         TxEop,
    output logic [7:0]                   OvfCnt,
    output logic [$clog2(FIFO_DEPTH):0]  FifoLevel
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PKT_L   = (AW+1)'(PKT_WORDS);
    localparam logic [AW:0] LAST_W  = (AW+1)'(PKT_WORDS - 1);

    typedef enum logic [2:0] {IDLE, SYNC0, SYNC1, SEQ, PAYLOAD, CHK} state_t;

    state_t        state;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   wcnt;
    logic [AW:0]   lvl_after;
    logic [1:0]    lane, lane_n;
    logic [7:0]    seq;
    logic [7:0]    pay_byte;
    logic [31:0]   rd_word, sel_word;
    logic          xfer, full, push, pop, last_word, start;
`ifdef SLANT_TX_CHKSUM_EN
    logic [7:0]    chk;
`endif

    always_comb begin
        xfer      = TxValid & TxReady;
        full      = (FifoLevel == DEPTH_L);
        push      = TransValid & ~full;
        pop       = xfer & (state == PAYLOAD) & (lane == 2'd3);
        last_word = (wcnt == LAST_W);
        lvl_after = FifoLevel - {{AW{1'b0}}, pop};
        start     = (lvl_after >= PKT_L);
        lane_n    = lane + 2'd1;
        rd_word   = mem[rptr];
        // Crossing into the next word: its lane 0 is already held in the FIFO
        sel_word  = (lane == 2'd3) ? mem[rptr + AW'(1)] : rd_word;
        pay_byte  = sel_word[{lane_n, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {Trans3Data, Trans2Data, Trans1Data, Trans0Data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr      <= '0;
            rptr      <= '0;
            FifoLevel <= '0;
            OvfCnt    <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   FifoLevel <= FifoLevel + (AW+1)'(1);
                2'b01:   FifoLevel <= FifoLevel - (AW+1)'(1);
                default: FifoLevel <= FifoLevel;
            endcase
            if (TransValid && full && OvfCnt != 8'hFF)
                OvfCnt <= OvfCnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            TxValid <= 1'b0;
            TxData  <= 8'h00;
            TxSof   <= 1'b0;
            TxEop   <= 1'b0;
            seq     <= 8'h00;
            wcnt    <= '0;
            lane    <= 2'd0;
`ifdef SLANT_TX_CHKSUM_EN
            chk     <= 8'h00;
`endif
        end else begin
            unique case (state)
                IDLE: if (FifoLevel >= PKT_L) begin
                    state   <= SYNC0;
                    TxValid <= 1'b1;
                    TxData  <= 8'hA5;
                    TxSof   <= 1'b1;
                    TxEop   <= 1'b0;
                end
                SYNC0: if (xfer) begin
                    state  <= SYNC1;
                    TxData <= 8'h5A;
                    TxSof  <= 1'b0;
                end
                SYNC1: if (xfer) begin
                    state  <= SEQ;
                    TxData <= seq;
`ifdef SLANT_TX_CHKSUM_EN
                    chk    <= seq;
`endif
                end
                SEQ: if (xfer) begin
                    state  <= PAYLOAD;
                    TxData <= rd_word[7:0];
                    lane   <= 2'd0;
                    wcnt   <= '0;
`ifdef SLANT_TX_CHKSUM_EN
                    chk    <= chk ^ rd_word[7:0];
`else
                    TxEop  <= 1'b0;
`endif
                end
                PAYLOAD: if (xfer) begin
                    if (lane == 2'd3 && last_word) begin
`ifdef SLANT_TX_CHKSUM_EN
                        state  <= CHK;
                        TxData <= chk;
                        TxEop  <= 1'b1;
`else
                        seq <= seq + 8'd1;
                        if (start) begin
                            state  <= SYNC0;
                            TxData <= 8'hA5;
                            TxSof  <= 1'b1;
                            TxEop  <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            TxValid <= 1'b0;
                            TxData  <= 8'h00;
                            TxEop   <= 1'b0;
                        end
`endif
                    end else begin
                        TxData <= pay_byte;
                        lane   <= lane_n;
                        if (lane == 2'd3)
                            wcnt <= wcnt + (AW+1)'(1);
`ifdef SLANT_TX_CHKSUM_EN
                        chk    <= chk ^ pay_byte;
`else
                        TxEop  <= last_word && (lane_n == 2'd3);
`endif
                    end
                end
`ifdef SLANT_TX_CHKSUM_EN
                CHK: if (xfer) begin
                    seq <= seq + 8'd1;
                    if (start) begin
                        state  <= SYNC0;
                        TxData <= 8'hA5;
                        TxSof  <= 1'b1;
                        TxEop  <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        TxValid <= 1'b0;
                        TxData  <= 8'h00;
                        TxEop   <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slant_tx_framer.sv
// Randomized scoreboard bench for slant_tx_framer.
// Expected bytes come from a packet-level model of accepted words.
module tb_slant_tx_framer;
    localparam int DEPTH = 16;
    localparam int PKT   = 4;
`ifdef SLANT_TX_CHKSUM_EN
    localparam int PKT_BYTES = 3 + PKT * 4 + 1;
`else
    localparam int PKT_BYTES = 3 + PKT * 4;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       TransValid = 1'b0;
    logic [7:0] t0 = '0, t1 = '0, t2 = '0, t3 = '0;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady = 1'b0;
    logic       TxSof, TxEop;
    logic [7:0] OvfCnt;
    logic [4:0] FifoLevel;

    slant_tx_framer #(.FIFO_DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
        .clk(clk), .rstn(rstn), .TransValid(TransValid),
        .Trans0Data(t0), .Trans1Data(t1), .Trans2Data(t2), .Trans3Data(t3),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .TxSof(TxSof), .TxEop(TxEop), .OvfCnt(OvfCnt), .FifoLevel(FifoLevel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eop;
        logic       pop;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] wq[$];
    logic [7:0]  seq_log[$];
    int compared = 0, mismatched = 0;
    int accepted = 0, popped = 0, m_ovf = 0, byte_cnt = 0, pkt_pos = 0;
    int mode = 0;
    logic [7:0] m_seq = 8'h00;
    logic hold_pending = 1'b0;
    logic [7:0] h_d;
    logic h_s, h_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Turn every complete group of accepted words into its expected packet
    task automatic form_packets();
        logic [31:0] w;
        logic [7:0]  b, c;
        while (wq.size() >= PKT) begin
            c = m_seq;
            expq.push_back('{8'hA5, 1'b1, 1'b0, 1'b0});
            expq.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
            expq.push_back('{m_seq, 1'b0, 1'b0, 1'b0});
            for (int k = 0; k < PKT; k++) begin
                w = wq.pop_front();
                for (int l = 0; l < 4; l++) begin
                    b = w[8*l +: 8];
                    c = c ^ b;
`ifdef SLANT_TX_CHKSUM_EN
                    expq.push_back('{b, 1'b0, 1'b0, l == 3});
`else
                    expq.push_back('{b, 1'b0, (k == PKT-1) && (l == 3), l == 3});
`endif
                end
            end
`ifdef SLANT_TX_CHKSUM_EN
            expq.push_back('{c, 1'b0, 1'b1, 1'b0});
`endif
            m_seq = m_seq + 8'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (mode)
            0:       TxReady = 1'b1;
            1:       TxReady = ~TxReady;
            2:       TxReady = 1'b0;
            default: TxReady = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic put_word(input logic [31:0] w, input logic v);
        TransValid = v;
        {t3, t2, t1, t0} = w;
        if (v) begin
            if (accepted - popped < DEPTH) begin
                accepted++;
                wq.push_back(w);
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
        tick();
        TransValid = 1'b0;
        form_packets();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (expq.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s drain timeout: %0d bytes left, expected 0", name, expq.size());
            expq.delete();
        end
        repeat (3) tick();
        check({name, " level"}, 32'(FifoLevel), 32'(accepted - popped));
        check({name, " ovf"}, 32'(OvfCnt), 32'(m_ovf));
    endtask

    task automatic clear_model();
        expq.delete();
        wq.delete();
        seq_log.delete();
        accepted = 0;
        popped = 0;
        m_ovf = 0;
        m_seq = 8'h00;
        byte_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " TxValid"}, 32'(TxValid), 0);
        check({name, " TxData"}, 32'(TxData), 0);
        check({name, " TxSof"}, 32'(TxSof), 0);
        check({name, " TxEop"}, 32'(TxEop), 0);
        check({name, " OvfCnt"}, 32'(OvfCnt), 0);
        check({name, " FifoLevel"}, 32'(FifoLevel), 0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks holds
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            hold_pending = 1'b0;
            pkt_pos = 0;
        end else begin
            if (hold_pending) begin
                compared++;
                if (!TxValid || TxData !== h_d || TxSof !== h_s || TxEop !== h_e) begin
                    mismatched++;
                    $display("FAIL hold: got v=%0b d=%0h s=%0b e=%0b, expected v=1 d=%0h s=%0b e=%0b",
                             TxValid, TxData, TxSof, TxEop, h_d, h_s, h_e);
                end
            end
            hold_pending = TxValid && !TxReady;
            h_d = TxData;
            h_s = TxSof;
            h_e = TxEop;
            if (TxValid && TxReady) begin
                byte_cnt++;
                pkt_pos = TxSof ? 0 : pkt_pos + 1;
                if (pkt_pos == 2)
                    seq_log.push_back(TxData);
                compared++;
                if (expq.size() == 0) begin
                    mismatched++;
                    $display("FAIL byte: got unexpected %0h, expected none", TxData);
                end else begin
                    e = expq.pop_front();
                    if (e.pop)
                        popped++;
                    if (TxData !== e.d || TxSof !== e.sof || TxEop !== e.eop) begin
                        mismatched++;
                        $display("FAIL byte: got d=%0h s=%0b e=%0b, expected d=%0h s=%0b e=%0b",
                                 TxData, TxSof, TxEop, e.d, e.sof, e.eop);
                    end
                end
            end
        end
    end

    initial begin
        int base, n;
        repeat (2) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        mode = 0;
        base = byte_cnt;
        for (int k = 0; k < 4; k++)
            put_word({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 1'b1);
        drain("basic");
        check("basic bytes", 32'(byte_cnt - base), 32'(PKT_BYTES));

        mode = 1;
        for (int k = 0; k < 4; k++)
            put_word({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 1'b1);
        drain("backpressure");

        mode = 2;
        for (int k = 0; k < 20; k++)
            put_word($urandom, 1'b1);
        tick();
        check("ovf level", 32'(FifoLevel), 32'(accepted - popped));
        check("ovf count", 32'(OvfCnt), 32'(m_ovf));
        mode = 0;
        drain("overflow");

        mode = 3;
        for (int k = 0; k < 400; k++)
            put_word($urandom, $urandom_range(0, 2) == 0);
        drain("random");

        mode = 0;
        for (int k = 0; k < 4; k++)
            put_word($urandom, 1'b1);
        n = 0;
        while (!(pkt_pos >= 4 && TxValid) && n < 200) begin
            tick();
            n++;
        end
        check("reach payload", 32'(n < 200), 1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        clear_model();
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        for (int k = 0; k < 4; k++)
            put_word($urandom, 1'b1);
        drain("after reset");
        check("after reset pkts", 32'(seq_log.size()), 1);
        if (seq_log.size() > 0)
            check("after reset seq", 32'(seq_log[0]), 0);

        rstn = 1'b0;
        #1;
        clear_model();
        tick();
        rstn = 1'b1;
        tick();
        mode = 3;
        for (int k = 0; k < 257 * PKT; k++) begin
            put_word($urandom, 1'b1);
            repeat (8) tick();
        end
        drain("wrap");
        check("wrap pkts", 32'(seq_log.size()), 257);
        if (seq_log.size() >= 257) begin
            check("wrap seq 256th", 32'(seq_log[255]), 32'hFF);
            check("wrap seq 257th", 32'(seq_log[256]), 32'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
